alu_exec_unit: RTL and testbench

- Handshaked execution ALU that consumes the 4-bit ALUOperation code produced by the ALU control decoder, together with two operands and a shift amount.
- Logic ops, ADD and LUI finish in one cycle. SLL/SRL run iteratively, one bit per cycle.
- Result is registered and held until the downstream stage (writeback/multicycle datapath) accepts it.
- Sits between the ALU control/register-read stage and writeback.

---
 rtl/alu_exec_unit.sv | 144 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execution ALU sitting between ALU control/register read and writeback.
// Logic ops, ADD and LUI complete in one cycle. SLL/SRL shift one bit per cycle. The result is
// registered and held until the downstream stage takes it.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready         request handshake (transfer when both high on a rising edge)
//   ALUOperation, A, B, shamt   op code from ALU control, operands, shift amount
//   result_valid / result_ready result handshake
//   ALUResult, Zero, Illegal    registered result and flags, valid while result_valid=1
module alu_exec_unit #(
  parameter int unsigned N_BITS     = 32,
  parameter int unsigned SHAMT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            ALUOperation,
  input  logic [N_BITS-1:0]     A,
  input  logic [N_BITS-1:0]     B,
  input  logic [SHAMT_BITS-1:0] shamt,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [N_BITS-1:0]     ALUResult,
  output logic                  Zero,
  output logic                  Illegal
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpNor = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpLui = 4'b0101;
  localparam logic [3:0] OpSll = 4'b0110;
  localparam logic [3:0] OpSrl = 4'b0111;

  state_e                r_state, w_state_next;
  logic [N_BITS-1:0]     r_work, w_work_next;
  logic [SHAMT_BITS-1:0] r_cnt, w_cnt_next;
  logic                  r_left, w_left_next;
  logic [N_BITS-1:0]     r_result, w_result_next;
  logic                  r_zero, w_zero_next;
  logic                  r_illegal, w_illegal_next;

  logic [N_BITS-1:0]     w_alu_out;
  logic                  w_alu_illegal;
  logic                  w_is_shift;
  logic [N_BITS-1:0]     w_shifted;

  // Single-cycle datapath; shift ops pass B through for the shamt=0 case.
  always_comb begin
    w_alu_out     = '0;
    w_alu_illegal = 1'b0;
    w_is_shift    = 1'b0;
    case (ALUOperation)
      OpAnd: w_alu_out = A & B;
      OpOr:  w_alu_out = A | B;
      OpNor: w_alu_out = ~(A | B);
      OpAdd: w_alu_out = A + B;
      OpLui: w_alu_out = {B[15:0], {(N_BITS-16){1'b0}}};
      OpSll, OpSrl: begin
        w_alu_out  = B;
        w_is_shift = 1'b1;
      end
      default: w_alu_illegal = 1'b1;
    endcase
  end

  assign w_shifted = r_left ? (r_work << 1) : (r_work >> 1);

  always_comb begin
    w_state_next   = r_state;
    w_work_next    = r_work;
    w_cnt_next     = r_cnt;
    w_left_next    = r_left;
    w_result_next  = r_result;
    w_zero_next    = r_zero;
    w_illegal_next = r_illegal;
    in_ready       = 1'b0;
    result_valid   = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_is_shift && (shamt != '0)) begin
            w_work_next  = B;
            w_cnt_next   = shamt;
            w_left_next  = (ALUOperation == OpSll);
            w_state_next = StShift;
          end else begin
            w_result_next  = w_alu_out;
            w_zero_next    = (w_alu_out == '0);
            w_illegal_next = w_alu_illegal;
            w_state_next   = StDone;
          end
        end
      end
      StShift: begin
        w_work_next = w_shifted;
        w_cnt_next  = r_cnt - 1'b1;
        // Last shift: counter hits zero after this step.
        if (r_cnt == SHAMT_BITS'(1)) begin
          w_result_next  = w_shifted;
          w_zero_next    = (w_shifted == '0);
          w_illegal_next = 1'b0;
          w_state_next   = StDone;
        end
      end
      StDone: begin
        result_valid = 1'b1;
        if (result_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_work    <= '0;
      r_cnt     <= '0;
      r_left    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_work    <= w_work_next;
      r_cnt     <= w_cnt_next;
      r_left    <= w_left_next;
      r_result  <= w_result_next;
      r_zero    <= w_zero_next;
      r_illegal <= w_illegal_next;
    end
  end

  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Illegal;

  int tests;
  int fails;

  alu_exec_unit #(
    .N_BITS    (32),
    .SHAMT_BITS(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUOperation(ALUOperation),
    .A           (A),
    .B           (B),
    .shamt       (shamt),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .Illegal     (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request and let it be accepted; returns #1 after the accepting edge with
  // inputs scrambled so only acceptance-time sampling can produce the right answer.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    ALUOperation = op;
    A            = a;
    B            = b;
    shamt        = sh;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    ALUOperation = 4'b1111;
    A            = 32'h5A5A_5A5A;
    B            = 32'hC3C3_C3C3;
    shamt        = 5'd9;
  endtask

  // Latency 1 means result_valid is already high right after the accepting edge.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!result_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0 ||
        Illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b ill=%b, want 1 0 00000000 0 0",
               in_ready, result_valid, ALUResult, Zero, Illegal);
    end
  endtask

  task automatic test_add();
    int lat;
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    wait_result(lat);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL add_latency: got %0d want 1", lat);
    end
    tests++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1 || Illegal !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL add_wrap: got res=%h z=%b ill=%b rdy=%b, want 00000000 1 0 0",
               ALUResult, Zero, Illegal, in_ready);
    end
    consume();
    tests++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL add_consume: got vld=%b rdy=%b want 0 1", result_valid, in_ready);
    end
  endtask

  task automatic test_logic();
    logic [3:0]  ops  [4] = '{4'b0010, 4'b0101, 4'b0000, 4'b0001};
    logic [31:0] av   [4] = '{32'h0F0F_0000, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'h1200_0000};
    logic [31:0] bv   [4] = '{32'h00F0_FFFF, 32'h0000_1234, 32'h0F0F_FFFF, 32'h0034_0056};
    logic [31:0] expv [4] = '{32'hF000_0000, 32'h1234_0000, 32'h0000_1234, 32'h1234_0056};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i], 5'd3);
      wait_result(lat);
      tests++;
      if (lat !== 1 || ALUResult !== expv[i] || Zero !== 1'b0 || Illegal !== 1'b0) begin
        fails++;
        $display("FAIL logic_op%0d: got lat=%0d res=%h z=%b ill=%b, want 1 %h 0 0",
                 i, lat, ALUResult, Zero, Illegal, expv[i]);
      end
      consume();
    end
  endtask

  task automatic test_shift();
    int lat;
    int busy_bad;
    issue(4'b0111, 32'h0, 32'h8000_0000, 5'd31);
    lat = 1;
    busy_bad = 0;
    while (!result_valid && lat < 200) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (lat !== 32 || busy_bad !== 0) begin
      fails++;
      $display("FAIL srl31_timing: got lat=%0d ready_high_cycles=%0d, want 32 0", lat, busy_bad);
    end
    tests++;
    if (ALUResult !== 32'h0000_0001 || Zero !== 1'b0 || Illegal !== 1'b0) begin
      fails++;
      $display("FAIL srl31_result: got res=%h z=%b ill=%b want 00000001 0 0",
               ALUResult, Zero, Illegal);
    end
    consume();

    issue(4'b0110, 32'h0, 32'hA5A5_A5A5, 5'd0);
    wait_result(lat);
    tests++;
    if (lat !== 1 || ALUResult !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL sll0: got lat=%0d res=%h want 1 a5a5a5a5", lat, ALUResult);
    end
    consume();

    issue(4'b0110, 32'h0, 32'h0000_0003, 5'd4);
    wait_result(lat);
    tests++;
    if (lat !== 5 || ALUResult !== 32'h0000_0030) begin
      fails++;
      $display("FAIL sll4: got lat=%0d res=%h want 5 00000030", lat, ALUResult);
    end
    consume();

    issue(4'b0110, 32'h0, 32'h8000_0001, 5'd1);
    wait_result(lat);
    tests++;
    if (lat !== 2 || ALUResult !== 32'h0000_0002 || Zero !== 1'b0) begin
      fails++;
      $display("FAIL sll1: got lat=%0d res=%h z=%b want 2 00000002 0", lat, ALUResult, Zero);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue(4'b0001, 32'h1111_0000, 32'h0000_2222, 5'd0);
    wait_result(lat);
    @(negedge clk);
    in_valid     = 1'b1;
    ALUOperation = 4'b0011;
    A            = 32'h1;
    B            = 32'h1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (result_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== 32'h1111_2222 ||
          Zero !== 1'b0 || Illegal !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL backpressure_hold: got %0d bad cycles want 0 (res=%h)", bad, ALUResult);
    end
    consume();
    tests++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b want 0 1", result_valid, in_ready);
    end
    issue(4'b0011, 32'h0000_0002, 32'h0000_0003, 5'd0);
    wait_result(lat);
    tests++;
    if (lat !== 1 || ALUResult !== 32'h0000_0005) begin
      fails++;
      $display("FAIL backpressure_next: got lat=%0d res=%h want 1 00000005", lat, ALUResult);
    end
    consume();
  endtask

  task automatic test_illegal();
    int lat;
    issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_result(lat);
    tests++;
    if (lat !== 1 || ALUResult !== 32'h0 || Illegal !== 1'b1 || Zero !== 1'b1) begin
      fails++;
      $display("FAIL illegal_1001: got lat=%0d res=%h ill=%b z=%b want 1 00000000 1 1",
               lat, ALUResult, Illegal, Zero);
    end
    consume();
    // A legal op afterwards must clear Illegal.
    issue(4'b0000, 32'hFFFF_0000, 32'h00FF_FF00, 5'd0);
    wait_result(lat);
    tests++;
    if (ALUResult !== 32'h00FF_0000 || Illegal !== 1'b0 || Zero !== 1'b0) begin
      fails++;
      $display("FAIL illegal_clear: got res=%h ill=%b z=%b want 00ff0000 0 0",
               ALUResult, Illegal, Zero);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(4'b0110, 32'h0, 32'h0000_0001, 5'd20);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0 ||
        Illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got rdy=%b vld=%b res=%h z=%b ill=%b want 1 0 00000000 0 0",
               in_ready, result_valid, ALUResult, Zero, Illegal);
    end
    @(negedge clk);
    reset = 1'b1;
    // No stale shift result may appear while idle.
    repeat (25) @(posedge clk);
    #1;
    tests++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_stale: got vld=%b rdy=%b want 0 1", result_valid, in_ready);
    end
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    wait_result(lat);
    tests++;
    if (lat !== 1 || ALUResult !== 32'h0000_F000 || Zero !== 1'b0 || Illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_after_and: got lat=%0d res=%h z=%b ill=%b want 1 0000f000 0 0",
               lat, ALUResult, Zero, Illegal);
    end
    consume();
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b0;
    in_valid     = 1'b0;
    result_ready = 1'b0;
    ALUOperation = 4'b0;
    A            = '0;
    B            = '0;
    shamt        = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_add();
    test_logic();
    test_shift();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
